// File: rtl/clock_pkg.sv
// Shared constants and helpers for the JC Pmod clock-divider bank.
package clock_pkg;

    localparam int CLK_HZ = 100_000_000;
    localparam int NUM_CH = 8;

    localparam int DEF_HALF_0 = 1;
    localparam int DEF_HALF_1 = 2;
    localparam int DEF_HALF_2 = 8;
    localparam int DEF_HALF_3 = 50;
    localparam int DEF_HALF_4 = 50_000;
    localparam int DEF_HALF_5 = 500_000;
    localparam int DEF_HALF_6 = 5_000_000;
    localparam int DEF_HALF_7 = 50_000_000;

    // A half-period of zero makes no sense, so it is treated as one cycle.
    function automatic int half_clamp(input int half);
        return (half < 1) ? 1 : half;
    endfunction

    // Counter width for a channel: wide enough to hold HALF-1, at least one bit.
    function automatic int cnt_width(input int half);
        return $clog2(half_clamp(half)) + 1;
    endfunction

endpackage

// File: rtl/clock_if.sv
// Bundle carrying the eight divided outputs toward the JC header.
interface clock_if
    import clock_pkg::*;
();
    logic [NUM_CH-1:0] JC;

    modport master (output JC);
    modport slave  (input  JC);
endinterface

// File: rtl/clock_div_channel.sv
// One divider channel: counts HALF cycles, then toggles its registered output.
module clock_div_channel
    import clock_pkg::*;
#(
    parameter int HALF = 1
) (
    input  logic clk,
    input  logic reset,
    output logic clk_out
);

    localparam int HALF_C = half_clamp(HALF);
    localparam int CNT_W  = cnt_width(HALF);
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(HALF_C - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             clk_out_r;

    // Count up to the terminal value, then wrap and flip the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= {CNT_W{1'b0}};
            clk_out_r <= 1'b0;
        end else if (cnt_r == TERM_CNT) begin
            cnt_r     <= {CNT_W{1'b0}};
            clk_out_r <= ~clk_out_r;
        end else begin
            cnt_r     <= cnt_r + CNT_ONE;
            clk_out_r <= clk_out_r;
        end
    end

    assign clk_out = clk_out_r;

endmodule

// File: rtl/clock.sv
// Eight-channel fixed-ratio divider bank driving the JC Pmod header.
// Outputs are plain fabric signals straight from flops; nothing here clocks on them.
module clock
    import clock_pkg::*;
#(
    parameter int HALF_0 = DEF_HALF_0,
    parameter int HALF_1 = DEF_HALF_1,
    parameter int HALF_2 = DEF_HALF_2,
    parameter int HALF_3 = DEF_HALF_3,
    parameter int HALF_4 = DEF_HALF_4,
    parameter int HALF_5 = DEF_HALF_5,
    parameter int HALF_6 = DEF_HALF_6,
    parameter int HALF_7 = DEF_HALF_7
) (
    input  logic     clk,
    input  logic     reset,
    clock_if.master  jc_bus
);

    localparam int HALVES [NUM_CH] = '{HALF_0, HALF_1, HALF_2, HALF_3,
                                       HALF_4, HALF_5, HALF_6, HALF_7};

    logic [NUM_CH-1:0] jc_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_div_channel #(
            .HALF (HALVES[i])
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .clk_out (jc_s[i])
        );
    end

    assign jc_bus.JC = jc_s;

endmodule

// File: tb/tb_clock.sv
// Directed bench for the JC divider bank: one default instance and one with
// HALF_3=0 (clamped to 1) and HALF_7=5, both sharing clk and reset.
module tb_clock;

    logic clk;
    logic reset;

    clock_if def_if ();
    clock_if ovr_if ();

    clock dut_def (
        .clk    (clk),
        .reset  (reset),
        .jc_bus (def_if)
    );

    clock #(
        .HALF_3 (0),
        .HALF_7 (5)
    ) dut_ovr (
        .clk    (clk),
        .reset  (reset),
        .jc_bus (ovr_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         edge_n;
        logic [7:0] exp_def;
        logic [7:0] exp_ovr;
    } vec_t;

    vec_t vecs [17];

    int checks   = 0;
    int failures = 0;
    int cur_edge = 0;

    int halves_def [8] = '{1, 2, 8, 50, 50_000, 500_000, 5_000_000, 50_000_000};
    int halves_ovr [8] = '{1, 2, 8, 1, 50_000, 500_000, 5_000_000, 5};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h expected=%h", name, cur_edge, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Closed-form expectation: bit i is high when floor(n/HALF_i) is odd.
    function automatic logic [7:0] model(input int halves [8], input int n);
        logic [7:0] r;
        int h;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            h = (halves[i] < 1) ? 1 : halves[i];
            r[i] = (((n / h) % 2) == 1);
        end
        return r;
    endfunction

    initial begin
        int highs;
        int rises;
        int falls;
        int first_rise;
        int second_rise;
        logic prev;
        logic [7:0] at_200;

        vecs[0]  = '{1,  8'h01, 8'h09};
        vecs[1]  = '{2,  8'h02, 8'h02};
        vecs[2]  = '{3,  8'h03, 8'h0B};
        vecs[3]  = '{4,  8'h00, 8'h00};
        vecs[4]  = '{5,  8'h01, 8'h89};
        vecs[5]  = '{6,  8'h02, 8'h82};
        vecs[6]  = '{7,  8'h03, 8'h8B};
        vecs[7]  = '{8,  8'h04, 8'h84};
        vecs[8]  = '{9,  8'h05, 8'h8D};
        vecs[9]  = '{10, 8'h06, 8'h06};
        vecs[10] = '{11, 8'h07, 8'h0F};
        vecs[11] = '{12, 8'h04, 8'h04};
        vecs[12] = '{13, 8'h05, 8'h0D};
        vecs[13] = '{14, 8'h06, 8'h06};
        vecs[14] = '{15, 8'h07, 8'h8F};
        vecs[15] = '{16, 8'h00, 8'h80};
        vecs[16] = '{17, 8'h01, 8'h89};

        // Reset held: outputs stay zero.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_hold_def", def_if.JC, 8'h00);
            check("reset_hold_ovr", ovr_if.JC, 8'h00);
        end

        // Release: the last step was edge 0 with reset sampled high.
        reset    = 1'b0;
        cur_edge = 0;
        for (int v = 0; v < 17; v++) begin
            while (cur_edge < vecs[v].edge_n) begin
                step();
                cur_edge++;
            end
            check("table_def", def_if.JC, vecs[v].exp_def);
            check("table_ovr", ovr_if.JC, vecs[v].exp_ovr);
        end

        // HALF_7=5: measure JC[7] over edges 20..39.
        while (cur_edge < 19) begin
            step();
            cur_edge++;
        end
        prev        = ovr_if.JC[7];
        highs       = 0;
        rises       = 0;
        first_rise  = -1;
        second_rise = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            cur_edge++;
            if (ovr_if.JC[7]) highs++;
            if (ovr_if.JC[7] && !prev) begin
                rises++;
                if (first_rise < 0) first_rise = cur_edge;
                else if (second_rise < 0) second_rise = cur_edge;
            end
            prev = ovr_if.JC[7];
        end
        check_int("half7_high_count", highs, 10);
        check_int("half7_rise_count", rises, 2);
        check_int("half7_first_rise", first_rise, 25);
        check_int("half7_period", second_rise - first_rise, 10);

        // Mid-operation reset while JC[1:0]=11.
        reset = 1'b1;
        step();
        reset    = 1'b0;
        cur_edge = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            cur_edge++;
        end
        check("pre_midreset_def", def_if.JC, 8'h03);
        check("pre_midreset_ovr", ovr_if.JC, 8'h0B);
        reset = 1'b1;
        step();
        check("midreset_def", def_if.JC, 8'h00);
        check("midreset_ovr", ovr_if.JC, 8'h00);
        reset    = 1'b0;
        cur_edge = 0;
        step();
        cur_edge++;
        check("restart_e1_def", def_if.JC, 8'h01);
        check("restart_e1_ovr", ovr_if.JC, 8'h09);
        step();
        cur_edge++;
        check("restart_e2_def", def_if.JC, 8'h02);
        check("restart_e2_ovr", ovr_if.JC, 8'h02);

        // Long run: 1000 edges against the closed-form model.
        reset = 1'b1;
        step();
        reset  = 1'b0;
        prev   = 1'b0;
        rises  = 0;
        falls  = 0;
        at_200 = 8'hFF;
        for (int n = 1; n <= 1000; n++) begin
            step();
            cur_edge = n;
            check("long_def", def_if.JC, model(halves_def, n));
            check("long_ovr", ovr_if.JC, model(halves_ovr, n));
            if (def_if.JC[3] && !prev) rises++;
            if (!def_if.JC[3] && prev) falls++;
            prev = def_if.JC[3];
            if (n == 200) at_200 = def_if.JC;
        end
        check_int("jc3_rises_1000", rises, 10);
        check_int("jc3_falls_1000", falls, 10);
        check("edge200_low_nibble", {4'h0, at_200[3:0]}, 8'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
